// File: rtl/btn_event_decoder.sv
// btn_event_decoder
//
// Turns a clean, clk-synchronous button level into single-cycle event pulses so that
// downstream control logic never has to edge-detect or time button holds itself.
//
// Parameters:
//   LONG_CYCLES   - hold time in clk cycles from press_pulse to long_pulse (>= 2)
//   REPEAT_CYCLES - clk cycles between repeat pulses after long_pulse; 0 disables repeat
//   CNT_W         - hold-counter width; 2**CNT_W must exceed max(LONG_CYCLES, REPEAT_CYCLES)
//
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - asynchronous active-low reset
//   btn_level     - debounced button level, 1 = pressed
//   press_pulse   - one-cycle pulse on an accepted press
//   release_pulse - one-cycle pulse on release from a held state
//   click_pulse   - one-cycle pulse alongside release_pulse for releases before the long threshold
//   long_pulse    - one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  - one-cycle pulse every REPEAT_CYCLES while held past the long threshold
//   held          - level, high while the button is held (pressed or long-held)
//
// All outputs are registered.

module btn_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        StWaitRelease,
        StIdle,
        StPressed,
        StLongHeld
    } state_e;

    localparam logic REPEAT_EN = (REPEAT_CYCLES != 0);

    // Terminal counts; the repeat one is unused (and kept at zero) when repeat is disabled.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST =
        REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic press_q, press_d;
    logic release_q, release_d;
    logic click_q, click_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            // A button that is down at reset must be let go before any event is accepted.
            StWaitRelease: begin
                if (!btn_level) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                if (btn_level) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end

            // Release is tested first so it wins over a threshold reached in the same cycle.
            StPressed: begin
                if (!btn_level) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = StLongHeld;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StLongHeld: begin
                if (!btn_level) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (REPEAT_EN) begin
                    if (cnt_q == REPEAT_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // With repeat disabled the counter simply holds.
            end

            default: begin
                state_d = StWaitRelease;
                cnt_d   = '0;
            end
        endcase

        // Taken from the next state so it rises with press_pulse and falls with release_pulse.
        held_d = (state_d == StPressed) || (state_d == StLongHeld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWaitRelease;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule
